alu_instr_sequencer: RTL and testbench

- Parametrised control-step sequencer that generates the per-cycle datapath control signals for fetch and execution of register-register ALU instructions (T0..T6).
- Replaces hand-sequenced control of Datapath during bring-up.
- Sits beside Datapath. It drives bus-source selects, register enables and alu_op, and receives the instruction register value back.
- Adds a memory-ready handshake, unary and HI/LO (mul/div) sequences, illegal-opcode detection and an optional auto-loop mode.

---
 rtl/alu_instr_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_alu_instr_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_instr_sequencer.sv
// Control-step sequencer for register-register ALU instructions (T0..T6).
// Outputs are decoded from the state register and the live IR contents only.
module alu_instr_sequencer #(
  parameter int DATA_W    = 32,
  parameter int OPC_W     = 5,
  parameter int REG_SEL_W = 4,
  parameter int AUTO_LOOP = 0,
  localparam int NREG     = 2 ** REG_SEL_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] ir,
  output logic              pc_out,
  output logic              zlo_out,
  output logic              zhi_out,
  output logic              mdr_out,
  output logic              mar_enable,
  output logic              pc_enable,
  output logic              pc_increment,
  output logic              mdr_enable,
  output logic              read,
  output logic              ir_enable,
  output logic              y_enable,
  output logic              z_enable,
  output logic              lo_enable,
  output logic              hi_enable,
  output logic [NREG-1:0]   reg_out_sel,
  output logic [NREG-1:0]   reg_in_sel,
  output logic [OPC_W-1:0]  alu_op,
  output logic              busy,
  output logic              done,
  output logic              illegal
);

  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, T6} state_t;

  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(5'b00011);
  localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(5'b00100);
  localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(5'b00101);
  localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(5'b00110);
  localparam logic [OPC_W-1:0] OP_ROR  = OPC_W'(5'b00111);
  localparam logic [OPC_W-1:0] OP_ROL  = OPC_W'(5'b01000);
  localparam logic [OPC_W-1:0] OP_SHR  = OPC_W'(5'b01001);
  localparam logic [OPC_W-1:0] OP_SHRA = OPC_W'(5'b01010);
  localparam logic [OPC_W-1:0] OP_SHL  = OPC_W'(5'b01011);
  localparam logic [OPC_W-1:0] OP_DIV  = OPC_W'(5'b01111);
  localparam logic [OPC_W-1:0] OP_MUL  = OPC_W'(5'b10000);
  localparam logic [OPC_W-1:0] OP_NEG  = OPC_W'(5'b10001);
  localparam logic [OPC_W-1:0] OP_NOT  = OPC_W'(5'b10010);

  state_t state_reg, state_next, done_next;

  logic [OPC_W-1:0]     op;
  logic [REG_SEL_W-1:0] ra, rb, rc;
  logic [NREG-1:0]      ra_hot, rb_hot, rc_hot;
  logic                 is_3reg, is_unary, is_hilo;

  assign op = ir[DATA_W-1 -: OPC_W];
  assign ra = ir[DATA_W-OPC_W-1 -: REG_SEL_W];
  assign rb = ir[DATA_W-OPC_W-REG_SEL_W-1 -: REG_SEL_W];
  assign rc = ir[DATA_W-OPC_W-2*REG_SEL_W-1 -: REG_SEL_W];

  // Low IR bits below rc carry no meaning for this instruction format.
  generate
    if (DATA_W > OPC_W + 3*REG_SEL_W) begin : g_low_bits
      logic unused_low;
      assign unused_low = ^ir[DATA_W-OPC_W-3*REG_SEL_W-1:0];
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_onehot
      assign ra_hot[gi] = (ra == REG_SEL_W'(gi));
      assign rb_hot[gi] = (rb == REG_SEL_W'(gi));
      assign rc_hot[gi] = (rc == REG_SEL_W'(gi));
    end
  endgenerate

  always_comb begin
    is_3reg  = 1'b0;
    is_unary = 1'b0;
    is_hilo  = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHRA, OP_SHL: is_3reg  = 1'b1;
      OP_NEG, OP_NOT:                  is_unary = 1'b1;
      OP_DIV, OP_MUL:                  is_hilo  = 1'b1;
      default:                         ;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  assign done_next = (AUTO_LOOP != 0) ? T0 : IDLE;

  always_comb begin
    state_next   = state_reg;
    pc_out       = 1'b0;
    zlo_out      = 1'b0;
    zhi_out      = 1'b0;
    mdr_out      = 1'b0;
    mar_enable   = 1'b0;
    pc_enable    = 1'b0;
    pc_increment = 1'b0;
    mdr_enable   = 1'b0;
    read         = 1'b0;
    ir_enable    = 1'b0;
    y_enable     = 1'b0;
    z_enable     = 1'b0;
    lo_enable    = 1'b0;
    hi_enable    = 1'b0;
    reg_out_sel  = '0;
    reg_in_sel   = '0;
    alu_op       = '0;
    done         = 1'b0;
    illegal      = 1'b0;
    busy         = (state_reg != IDLE);
    case (state_reg)
      IDLE: if (start) state_next = T0;
      T0: begin
        pc_out       = 1'b1;
        mar_enable   = 1'b1;
        pc_increment = 1'b1;
        state_next   = T1;
      end
      T1: begin
        read       = 1'b1;
        mdr_enable = 1'b1;
        if (mem_ready) state_next = T2;
      end
      T2: begin
        mdr_out    = 1'b1;
        ir_enable  = 1'b1;
        state_next = T3;
      end
      T3: begin
        // First cycle in which the freshly loaded opcode is visible.
        if (is_3reg) begin
          reg_out_sel = rb_hot;
          y_enable    = 1'b1;
          state_next  = T4;
        end else if (is_hilo) begin
          reg_out_sel = ra_hot;
          y_enable    = 1'b1;
          state_next  = T4;
        end else if (is_unary) begin
          state_next  = T4;
        end else begin
          illegal     = 1'b1;
          state_next  = IDLE;
        end
      end
      T4: begin
        alu_op      = op;
        z_enable    = 1'b1;
        reg_out_sel = is_3reg ? rc_hot : rb_hot;
        state_next  = T5;
      end
      T5: begin
        zlo_out = 1'b1;
        if (is_hilo) begin
          lo_enable  = 1'b1;
          state_next = T6;
        end else begin
          reg_in_sel = ra_hot;
          done       = 1'b1;
          state_next = done_next;
        end
      end
      T6: begin
        zhi_out    = 1'b1;
        hi_enable  = 1'b1;
        done       = 1'b1;
        state_next = done_next;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Scoreboard bench: stimulus queues the expected per-cycle control word,
// monitors pop and compare on every busy cycle and require zeros otherwise.
module tb_alu_instr_sequencer;

  localparam logic [15:0] S_PC_OUT = 16'h0001, S_ZLO  = 16'h0002, S_ZHI   = 16'h0004,
                          S_MDRO   = 16'h0008, S_MAR  = 16'h0010, S_PCEN  = 16'h0020,
                          S_PCINC  = 16'h0040, S_MDRE = 16'h0080, S_READ  = 16'h0100,
                          S_IRE    = 16'h0200, S_Y    = 16'h0400, S_Z     = 16'h0800,
                          S_LO     = 16'h1000, S_HI   = 16'h2000, S_DONE  = 16'h4000,
                          S_ILL    = 16'h8000;

  localparam logic [31:0] IR_SHL = 32'h5A1B8000, IR_MUL = 32'h81280000,
                          IR_NEG = 32'h88B00000, IR_AND0 = 32'h28000000,
                          IR_NOT15 = 32'h97F80000, IR_ILL = 32'hF8000000,
                          IR_ILL0 = 32'h00000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int stall_left = 0;

  // Instance with AUTO_LOOP=0
  logic        clr, start, mem_ready;
  logic [31:0] ir;
  logic        pc_out, zlo_out, zhi_out, mdr_out, mar_enable, pc_enable, pc_increment;
  logic        mdr_enable, read, ir_enable, y_enable, z_enable, lo_enable, hi_enable;
  logic [15:0] reg_out_sel, reg_in_sel;
  logic [4:0]  alu_op;
  logic        busy, done, illegal;
  logic [52:0] w1;

  // Instance with AUTO_LOOP=1
  logic        a_clr, a_start;
  logic [31:0] a_ir;
  logic        a_pc_out, a_zlo_out, a_zhi_out, a_mdr_out, a_mar_enable, a_pc_enable, a_pc_increment;
  logic        a_mdr_enable, a_read, a_ir_enable, a_y_enable, a_z_enable, a_lo_enable, a_hi_enable;
  logic [15:0] a_reg_out_sel, a_reg_in_sel;
  logic [4:0]  a_alu_op;
  logic        a_busy, a_done, a_illegal;
  logic [52:0] w2;

  logic [52:0] q1[$];
  logic [52:0] q2[$];

  alu_instr_sequencer #(.AUTO_LOOP(0)) dut (
    .clk(clk), .clr(clr), .start(start), .mem_ready(mem_ready), .ir(ir),
    .pc_out(pc_out), .zlo_out(zlo_out), .zhi_out(zhi_out), .mdr_out(mdr_out),
    .mar_enable(mar_enable), .pc_enable(pc_enable), .pc_increment(pc_increment),
    .mdr_enable(mdr_enable), .read(read), .ir_enable(ir_enable), .y_enable(y_enable),
    .z_enable(z_enable), .lo_enable(lo_enable), .hi_enable(hi_enable),
    .reg_out_sel(reg_out_sel), .reg_in_sel(reg_in_sel), .alu_op(alu_op),
    .busy(busy), .done(done), .illegal(illegal)
  );

  alu_instr_sequencer #(.AUTO_LOOP(1)) dut_loop (
    .clk(clk), .clr(a_clr), .start(a_start), .mem_ready(1'b1), .ir(a_ir),
    .pc_out(a_pc_out), .zlo_out(a_zlo_out), .zhi_out(a_zhi_out), .mdr_out(a_mdr_out),
    .mar_enable(a_mar_enable), .pc_enable(a_pc_enable), .pc_increment(a_pc_increment),
    .mdr_enable(a_mdr_enable), .read(a_read), .ir_enable(a_ir_enable), .y_enable(a_y_enable),
    .z_enable(a_z_enable), .lo_enable(a_lo_enable), .hi_enable(a_hi_enable),
    .reg_out_sel(a_reg_out_sel), .reg_in_sel(a_reg_in_sel), .alu_op(a_alu_op),
    .busy(a_busy), .done(a_done), .illegal(a_illegal)
  );

  assign w1 = {illegal, done, hi_enable, lo_enable, z_enable, y_enable, ir_enable, read,
               mdr_enable, pc_increment, pc_enable, mar_enable, mdr_out, zhi_out, zlo_out,
               pc_out, reg_out_sel, reg_in_sel, alu_op};
  assign w2 = {a_illegal, a_done, a_hi_enable, a_lo_enable, a_z_enable, a_y_enable, a_ir_enable,
               a_read, a_mdr_enable, a_pc_increment, a_pc_enable, a_mar_enable, a_mdr_out,
               a_zhi_out, a_zlo_out, a_pc_out, a_reg_out_sel, a_reg_in_sel, a_alu_op};

  task automatic check(input bit ok, input string nm, input logic [52:0] act, input logic [52:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [52:0] mk(input logic [15:0] s, input logic [15:0] osel,
                                     input logic [15:0] isel, input logic [4:0] op);
    return {s, osel, isel, op};
  endfunction

  task automatic push1(input logic [15:0] s, input logic [15:0] o, input logic [15:0] i, input logic [4:0] op);
    q1.push_back(mk(s, o, i, op));
  endtask
  task automatic push2(input logic [15:0] s, input logic [15:0] o, input logic [15:0] i, input logic [4:0] op);
    q2.push_back(mk(s, o, i, op));
  endtask

  // Fetch T0..T2, with one extra T1 cycle per memory stall
  task automatic fetch1(input int stalls);
    push1(S_PC_OUT | S_MAR | S_PCINC, 0, 0, 0);
    for (int k = 0; k <= stalls; k++) push1(S_READ | S_MDRE, 0, 0, 0);
    push1(S_MDRO | S_IRE, 0, 0, 0);
  endtask
  task automatic fetch2();
    push2(S_PC_OUT | S_MAR | S_PCINC, 0, 0, 0);
    push2(S_READ | S_MDRE, 0, 0, 0);
    push2(S_MDRO | S_IRE, 0, 0, 0);
  endtask

  task automatic launch(input logic [31:0] instr, input string nm);
    ir = instr;
    $display("txn %s ir=%h stalls=%0d", nm, instr, stall_left);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_empty(input string nm);
    for (int k = 0; k < 60; k++) begin
      if (q1.size() == 0) break;
      @(posedge clk); #1;
    end
    check(q1.size() == 0, {nm, "_timeout"}, 53'(q1.size()), 0);
    q1.delete();
  endtask

  task automatic drain(input string nm);
    wait_empty(nm);
    check(busy == 1'b0, {nm, "_busy_drop"}, 53'(busy), 0);
  endtask

  // Memory model: withholds mem_ready for stall_left T1 cycles
  always @(negedge clk) begin
    if (read && stall_left > 0) begin
      mem_ready = 1'b0;
      stall_left--;
    end else begin
      mem_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (busy) begin
      if (q1.size() == 0) check(1'b0, "dut_extra_busy_cycle", w1, 0);
      else begin
        logic [52:0] e;
        e = q1.pop_front();
        check(w1 === e, "dut_cycle", w1, e);
      end
    end else begin
      check(w1 === 53'd0, "dut_idle_zero", w1, 0);
    end
  end

  always @(negedge clk) begin
    if (a_busy) begin
      if (q2.size() == 0) check(1'b0, "loop_extra_busy_cycle", w2, 0);
      else begin
        logic [52:0] e;
        e = q2.pop_front();
        check(w2 === e, "loop_cycle", w2, e);
      end
    end else begin
      check(w2 === 53'd0, "loop_idle_zero", w2, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b1; start = 1'b0; ir = '0;
    a_clr = 1'b1; a_start = 1'b0; a_ir = '0;
    #1;
    check(w1 === 53'd0 && busy === 1'b0, "reset_outputs", {w1[51:0], busy}, 0);
    check(w2 === 53'd0 && a_busy === 1'b0, "reset_outputs_loop", {w2[51:0], a_busy}, 0);
    repeat (2) @(posedge clk);
    #1 clr = 1'b0; a_clr = 1'b0;

    // shl R4,R3,R7
    fetch1(0);
    push1(S_Y, 16'h0008, 0, 0);
    push1(S_Z, 16'h0080, 0, 5'b01011);
    push1(S_ZLO | S_DONE, 0, 16'h0010, 0);
    launch(IR_SHL, "shl");
    drain("shl");

    // shl with three memory stalls
    stall_left = 3;
    fetch1(3);
    push1(S_Y, 16'h0008, 0, 0);
    push1(S_Z, 16'h0080, 0, 5'b01011);
    push1(S_ZLO | S_DONE, 0, 16'h0010, 0);
    launch(IR_SHL, "shl_stall");
    drain("shl_stall");

    // mul R2,R5
    fetch1(0);
    push1(S_Y, 16'h0004, 0, 0);
    push1(S_Z, 16'h0020, 0, 5'b10000);
    push1(S_ZLO | S_LO, 0, 0, 0);
    push1(S_ZHI | S_HI | S_DONE, 0, 0, 0);
    launch(IR_MUL, "mul");
    drain("mul");

    // neg R1,R6
    fetch1(0);
    push1(0, 0, 0, 0);
    push1(S_Z, 16'h0040, 0, 5'b10001);
    push1(S_ZLO | S_DONE, 0, 16'h0002, 0);
    launch(IR_NEG, "neg");
    drain("neg");

    // and R0,R0,R0
    fetch1(0);
    push1(S_Y, 16'h0001, 0, 0);
    push1(S_Z, 16'h0001, 0, 5'b00101);
    push1(S_ZLO | S_DONE, 0, 16'h0001, 0);
    launch(IR_AND0, "and_r0");
    drain("and_r0");

    // not R15,R15
    fetch1(0);
    push1(0, 0, 0, 0);
    push1(S_Z, 16'h8000, 0, 5'b10010);
    push1(S_ZLO | S_DONE, 0, 16'h8000, 0);
    launch(IR_NOT15, "not_r15");
    drain("not_r15");

    // illegal opcodes 11111 and 00000
    fetch1(0);
    push1(S_ILL, 0, 0, 0);
    launch(IR_ILL, "illegal_1f");
    drain("illegal_1f");
    fetch1(0);
    push1(S_ILL, 0, 0, 0);
    launch(IR_ILL0, "illegal_00");
    drain("illegal_00");

    // clr asserted in the middle of T4
    fetch1(0);
    push1(S_Y, 16'h0008, 0, 0);
    launch(IR_SHL, "shl_abort");
    wait_empty("shl_abort");
    check(z_enable === 1'b1 && alu_op === 5'b01011, "abort_in_t4", {z_enable, alu_op}, 6'h2B);
    clr = 1'b1;
    #1;
    check(w1 === 53'd0 && busy === 1'b0, "clr_outputs", {w1[51:0], busy}, 0);
    @(posedge clk); #1 clr = 1'b0;
    fetch1(0);
    push1(S_Y, 16'h0008, 0, 0);
    push1(S_Z, 16'h0080, 0, 5'b01011);
    push1(S_ZLO | S_DONE, 0, 16'h0010, 0);
    launch(IR_SHL, "shl_after_clr");
    drain("shl_after_clr");

    // AUTO_LOOP: shl then mul without a second start
    fetch2();
    push2(S_Y, 16'h0008, 0, 0);
    push2(S_Z, 16'h0080, 0, 5'b01011);
    push2(S_ZLO | S_DONE, 0, 16'h0010, 0);
    fetch2();
    push2(S_Y, 16'h0004, 0, 0);
    push2(S_Z, 16'h0020, 0, 5'b10000);
    push2(S_ZLO | S_LO, 0, 0, 0);
    push2(S_ZHI | S_HI | S_DONE, 0, 0, 0);
    a_ir = IR_SHL;
    $display("txn autoloop shl->mul ir=%h,%h", IR_SHL, IR_MUL);
    @(posedge clk); #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (a_done) break;
    end
    @(posedge clk); #1 a_ir = IR_MUL;
    for (int k = 0; k < 60; k++) begin
      if (q2.size() == 0) break;
      @(posedge clk); #1;
    end
    check(q2.size() == 0, "autoloop_timeout", 53'(q2.size()), 0);
    q2.delete();
    check(a_busy === 1'b1 && a_pc_out === 1'b1, "autoloop_relaunch", {a_busy, a_pc_out}, 2'b11);
    a_clr = 1'b1;
    #1;
    check(a_busy === 1'b0, "autoloop_clr", 53'(a_busy), 0);
    @(posedge clk); #1 a_clr = 1'b0;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
